// File: rtl/mcsr_file.sv
// mcsr_file: machine-mode CSR file with trap entry, mret and interrupt arbitration.
// Define MCSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module mcsr_file #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_tval,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   input  logic            instret,
   input  logic [1:0]      cur_priv,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            trap_taken,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_out,
   output logic [1:0]      next_priv,
   output logic            irq_pending
);

   localparam logic [11:0] CsrMstatus  = 12'h300;
   localparam logic [11:0] CsrMie      = 12'h304;
   localparam logic [11:0] CsrMtvec    = 12'h305;
   localparam logic [11:0] CsrMscratch = 12'h340;
   localparam logic [11:0] CsrMepc     = 12'h341;
   localparam logic [11:0] CsrMcause   = 12'h342;
   localparam logic [11:0] CsrMtval    = 12'h343;
   localparam logic [11:0] CsrMip      = 12'h344;

   logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
   logic [1:0]      st_mpp_q, st_mpp_d, priv_q, priv_d;
   // Interrupt bit vectors are packed as {MEI, MTI, MSI}.
   logic [2:0]      mie_q, mie_d, mip_q, mip_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
   logic [XLEN-1:0] mstatus_rd, mtvec_base;
   logic            int_take, trap, csr_wr;
   logic [3:0]      int_cause;

   function automatic logic [XLEN-1:0] irq_bits(input logic [2:0] b);
      logic [XLEN-1:0] r;
      r     = '0;
      r[3]  = b[0];
      r[7]  = b[1];
      r[11] = b[2];
      return r;
   endfunction

   assign irq_pending = |(mie_q & mip_q);
   assign int_take    = irq_pending && !exc_valid && (st_mie_q || cur_priv == 2'b00) && !reset;
   assign trap        = (exc_valid && !reset) || int_take;
   assign trap_taken  = trap;
   assign csr_wr      = csr_we && !trap && !mret;
   assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
   assign next_priv   = priv_q;
   assign mepc_out    = mepc_q;

   always_comb begin
      int_cause = 4'd7;
      if (mie_q[2] && mip_q[2]) begin
         int_cause = 4'd11;
      end else if (mie_q[0] && mip_q[0]) begin
         int_cause = 4'd3;
      end
   end

   always_comb begin
      trap_vector = mtvec_base;
      if (!exc_valid && mtvec_q[0]) begin
         trap_vector = mtvec_base + XLEN'({int_cause, 2'b00});
      end
   end

   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[3]     = st_mie_q;
      mstatus_rd[7]     = st_mpie_q;
      mstatus_rd[12:11] = st_mpp_q;
   end

   always_comb begin
      st_mie_d   = st_mie_q;
      st_mpie_d  = st_mpie_q;
      st_mpp_d   = st_mpp_q;
      priv_d     = priv_q;
      mie_d      = mie_q;
      mip_d      = {irq_ext, irq_timer, irq_sw};
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      if (trap) begin
         mepc_d    = trap_pc;
         st_mpie_d = st_mie_q;
         st_mie_d  = 1'b0;
         st_mpp_d  = cur_priv;
         priv_d    = 2'b11;
         if (exc_valid) begin
            mcause_d = {1'b0, {(XLEN-5){1'b0}}, exc_cause};
            mtval_d  = exc_tval;
         end else begin
            mcause_d = {1'b1, {(XLEN-5){1'b0}}, int_cause};
            mtval_d  = '0;
         end
      end else if (mret) begin
         st_mie_d  = st_mpie_q;
         st_mpie_d = 1'b1;
         st_mpp_d  = 2'b00;
         priv_d    = st_mpp_q;
      end else if (csr_wr) begin
         case (csr_waddr)
            CsrMstatus: begin
               st_mie_d  = csr_wdata[3];
               st_mpie_d = csr_wdata[7];
               // Only U (00) and M (11) are supported; other MPP values are dropped.
               if (csr_wdata[12:11] == 2'b00 || csr_wdata[12:11] == 2'b11) begin
                  st_mpp_d = csr_wdata[12:11];
               end
            end
            CsrMie:      mie_d      = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
            CsrMtvec:    mtvec_d    = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[1:0] == 2'b01};
            CsrMscratch: mscratch_d = csr_wdata;
            CsrMepc:     mepc_d     = {csr_wdata[XLEN-1:2], 2'b00};
            CsrMcause:   mcause_d   = csr_wdata;
            CsrMtval:    mtval_d    = csr_wdata;
            default: ;
         endcase
      end
   end

`ifdef MCSR_COUNTERS_EN
   localparam logic [11:0] CsrMcycle    = 12'hB00;
   localparam logic [11:0] CsrMinstret  = 12'hB02;
   localparam logic [11:0] CsrMcycleh   = 12'hB80;
   localparam logic [11:0] CsrMinstreth = 12'hB82;

   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   // A CSR write replaces only the half it targets; the other half still counts.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, instret};
      if (csr_wr) begin
         case (csr_waddr)
            CsrMcycle:    mcycle_d[XLEN-1:0]   = csr_wdata;
            CsrMinstret:  minstret_d[XLEN-1:0] = csr_wdata;
            CsrMcycleh:   if (XLEN == 32) mcycle_d[63:32] = csr_wdata[31:0];
            CsrMinstreth: if (XLEN == 32) minstret_d[63:32] = csr_wdata[31:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic unused_instret;
   assign unused_instret = instret;
`endif

   always_comb begin
      csr_rdata   = '0;
      csr_illegal = 1'b0;
      case (csr_addr)
         CsrMstatus:  csr_rdata = mstatus_rd;
         CsrMie:      csr_rdata = irq_bits(mie_q);
         CsrMtvec:    csr_rdata = mtvec_q;
         CsrMscratch: csr_rdata = mscratch_q;
         CsrMepc:     csr_rdata = mepc_q;
         CsrMcause:   csr_rdata = mcause_q;
         CsrMtval:    csr_rdata = mtval_q;
         CsrMip:      csr_rdata = irq_bits(mip_q);
`ifdef MCSR_COUNTERS_EN
         CsrMcycle:   csr_rdata = mcycle_q[XLEN-1:0];
         CsrMinstret: csr_rdata = minstret_q[XLEN-1:0];
         CsrMcycleh: begin
            if (XLEN == 32) csr_rdata = XLEN'(mcycle_q[63:32]);
            else csr_illegal = 1'b1;
         end
         CsrMinstreth: begin
            if (XLEN == 32) csr_rdata = XLEN'(minstret_q[63:32]);
            else csr_illegal = 1'b1;
         end
`endif
         default:     csr_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_mie_q   <= 1'b0;
         st_mpie_q  <= 1'b0;
         st_mpp_q   <= 2'b11;
         priv_q     <= 2'b11;
         mie_q      <= '0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         st_mie_q   <= st_mie_d;
         st_mpie_q  <= st_mpie_d;
         st_mpp_q   <= st_mpp_d;
         priv_q     <= priv_d;
         mie_q      <= mie_d;
         mip_q      <= mip_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

endmodule

// File: doc/mcsr_file.md
MCSR_FILE -- requirements
Module: mcsr_file

Interface
REQ-001 SHALL have parameter XLEN, 32, register/data width; legal values 32 or 64.
REQ-002 SHALL have parameter MTVEC_RESET, 0, mtvec reset value.
REQ-003 SHALL have ports clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-004 SHALL have ports csr_addr in 12, read address; csr_rdata out XLEN, read data; csr_illegal out 1, csr_addr unimplemented.
REQ-005 SHALL have ports csr_we in 1, write strobe; csr_waddr in 12; csr_wdata in XLEN.
REQ-006 SHALL have ports exc_valid in 1, synchronous exception; exc_cause in 4; exc_tval in XLEN; trap_pc in XLEN, PC of the faulting or interrupted instruction.
REQ-007 SHALL have ports mret in 1; instret in 1, one instruction retired this cycle; cur_priv in 2, current privilege.
REQ-008 SHALL have ports irq_sw, irq_timer, irq_ext in 1 each, level-sensitive interrupt lines.
REQ-009 SHALL have ports trap_taken out 1; trap_vector out XLEN; mepc_out out XLEN; next_priv out 2 (registered); irq_pending out 1.

Function
REQ-010 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344; all other addresses SHALL set csr_illegal=1 and read 0.
REQ-011 SHALL make reads combinational, with zero latency.
REQ-012 SHALL register all state updates on the rising clk edge; the event priority per cycle SHALL be exc_valid > interrupt take > mret > csr_we.
REQ-013 SHALL make mip read-only; mip[3]/[7]/[11] SHALL mirror irq_sw/irq_timer/irq_ext, registered one cycle.
REQ-014 SHALL make only mie bits 3/7/11 and mstatus MIE[3]/MPIE[7]/MPP[12:11] writable; all other bits SHALL read 0.
REQ-015 SHALL ignore an MPP write of 01 or 10 and retain the old MPP.
REQ-016 SHALL store an mtvec MODE write of 2 or 3 as 0; a write to mepc SHALL force bits[1:0] to 0.
REQ-017 SHALL assert irq_pending = |(mie & mip); an interrupt SHALL be taken when irq_pending is 1, exc_valid is 0, and (mstatus.MIE is 1 or cur_priv is 00).
REQ-018 SHALL select the interrupt cause by priority MEI(11) > MSI(3) > MTI(7).
REQ-019 SHALL drive trap_taken combinationally in the same cycle as exc_valid or an interrupt take.
REQ-020 SHALL drive trap_vector = mtvec BASE for exceptions, and BASE + 4*cause for interrupts when MODE is 1.
REQ-021 SHALL perform trap entry at the edge: mepc<=trap_pc, MPIE<=MIE, MIE<=0, MPP<=cur_priv, next_priv<=11.
REQ-022 SHALL set mcause on trap entry to {0,exc_cause} for exceptions and {1,cause} for interrupts, with the interrupt flag in the MSB.
REQ-023 SHALL load mtval with exc_tval on exception entry and clear mtval to 0 on interrupt entry.
REQ-024 SHALL perform mret at the edge: MIE<=MPIE, MPIE<=1, MPP<=00, next_priv<=old MPP.
REQ-025 SHALL drop a csr_we that occurs in the same cycle as a trap or mret.

Reset
REQ-026 SHALL, while reset is high and regardless of clk, hold mstatus=0x1800 (MIE=0, MPP=11), mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mtval=0, mip=0, next_priv=11, and counters=0.
REQ-027 SHALL make an interrupt or exception coincident with reset have no effect.

Configuration
REQ-028 SHALL, when macro MCSR_COUNTERS_EN is defined, implement 64-bit mcycle 0xB00 (+1 every cycle) and minstret 0xB02 (+1 when instret is 1), both wrapping to 0.
REQ-029 SHALL, with MCSR_COUNTERS_EN and XLEN=32, expose the upper halves at 0xB80/0xB82; with XLEN=64, 0xB80/0xB82 SHALL be illegal.
REQ-030 SHALL, with MCSR_COUNTERS_EN, let a write to a counter half override that cycle's increment for that half only.
REQ-031 SHALL, when MCSR_COUNTERS_EN is undefined, make all counter addresses illegal and read 0, with no counter flops.

Verification
REQ-032 SHALL cover: release reset -> mstatus reads 0x1800, mtvec=MTVEC_RESET, next_priv=11, csr_illegal=1 at 0x7C0.
REQ-033 SHALL cover: mtvec=0x100 MODE 1, mie=0x888, MIE=1, irq_ext=1 -> trap_taken, trap_vector=0x12C, mcause=0x8000000B, MIE=0.
REQ-034 SHALL cover: exc_valid with cause 2, tval 0xDEAD, trap_pc 0x40, all irqs high -> mcause=2, mtval=0xDEAD, mepc=0x40, trap_vector=0x100.
REQ-035 SHALL cover: cur_priv=00, exception taken, then mret -> next_priv=00, MIE restored, MPIE=1, MPP=00.
REQ-036 SHALL cover: with MCSR_COUNTERS_EN, write mcycle=0xFFFFFFFF and mcycleh=0 -> next cycle mcycle=0, mcycleh=1.
REQ-037 SHALL cover: mstatus write 0xFFFFFFFF with MPP=11 held, then write MPP=01 -> mstatus reads 0x1888, MPP unchanged.
